// File: rtl/seq_match_counter.sv
// Streaming KMP-style pattern detector; SEQ_OVERLAP_EN enables overlapping matches. Latency 1 clk (hit/ans/hit_cnt registered).
// No backpressure: a symbol is consumed on every edge with in_valid=1 and clear=0; priority reset > clear > in_valid.
module seq_match_counter #(
  parameter int SYM_W   = 2,
  parameter int SEQ_LEN = 3,
  parameter logic [SYM_W*SEQ_LEN-1:0] PATTERN = 6'b11_10_01,
  parameter int CNT_W   = 8,
  localparam int PW     = $clog2(SEQ_LEN+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [SYM_W-1:0] num,
  output logic             hit,
  output logic             ans,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [PW-1:0]    progress
);

  localparam logic [PW-1:0] HIST_MAX = PW'(SEQ_LEN - 1);

  // hist[0] is the most recent accepted symbol; hcnt counts how many entries are valid
  logic [SYM_W-1:0] hist [SEQ_LEN-1];
  logic [PW-1:0]    hcnt;

  logic             full_m;
  logic [PW-1:0]    part_len;
  logic             ok;

  // Longest pattern prefix ending at the incoming symbol; full_m flags a complete match,
  // part_len keeps the longest proper one (the post-match border in overlap mode).
  always_comb begin
    full_m   = 1'b0;
    part_len = '0;
    ok       = 1'b0;
    for (int k = 1; k <= SEQ_LEN; k++) begin
      ok = (int'(hcnt) >= k - 1);
      for (int j = 0; j < k - 1; j++) begin
        if (hist[k-2-j] != PATTERN[j*SYM_W +: SYM_W]) ok = 1'b0;
      end
      if (num != PATTERN[(k-1)*SYM_W +: SYM_W]) ok = 1'b0;
      if (ok) begin
        if (k == SEQ_LEN) full_m = 1'b1;
        else              part_len = PW'(k);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit      <= 1'b0;
      ans      <= 1'b0;
      hit_cnt  <= '0;
      progress <= '0;
      hcnt     <= '0;
      for (int i = 0; i < SEQ_LEN - 1; i++) hist[i] <= '0;
    end else if (clear) begin
      hit      <= 1'b0;
      ans      <= 1'b0;
      hit_cnt  <= '0;
      progress <= '0;
      hcnt     <= '0;
    end else if (in_valid) begin
      for (int i = SEQ_LEN - 2; i > 0; i--) hist[i] <= hist[i-1];
      hist[0] <= num;
      if (hcnt != HIST_MAX) hcnt <= hcnt + 1'b1;
      hit <= full_m;
      if (full_m) begin
        ans <= 1'b1;
        if (hit_cnt != {CNT_W{1'b1}}) hit_cnt <= hit_cnt + 1'b1;
`ifdef SEQ_OVERLAP_EN
        progress <= part_len;
`else
        // matched symbols may not seed the next match
        progress <= '0;
        hcnt     <= '0;
`endif
      end else begin
        progress <= part_len;
      end
    end else begin
      hit <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_match_counter.sv
// Directed + random bench for seq_match_counter; four instances share one stimulus stream.
module tb_seq_match_counter;

`ifdef SEQ_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic       in_valid;
  logic [1:0] num;

  logic       h [4];
  logic       a [4];
  logic [1:0] p [4];
  logic [7:0] c0, c1, c3;
  logic [1:0] c2;

  int checks = 0;
  int errors = 0;

  // reference model: recent accepted stream as a queue, matched against pattern directly
  int mq [4][$];
  int mp [4];
  int mans [4];
  int mhit [4];
  int mcnt [4];
  int pat [4][3] = '{'{1,2,3}, '{1,1,1}, '{1,2,3}, '{1,2,1}};
  int cmax [4] = '{255, 255, 3, 255};

  always #5 clk = ~clk;

  seq_match_counter #(.SYM_W(2), .SEQ_LEN(3), .PATTERN(6'b11_10_01), .CNT_W(8)) u0 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .num(num),
    .hit(h[0]), .ans(a[0]), .hit_cnt(c0), .progress(p[0]));
  seq_match_counter #(.SYM_W(2), .SEQ_LEN(3), .PATTERN(6'b01_01_01), .CNT_W(8)) u1 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .num(num),
    .hit(h[1]), .ans(a[1]), .hit_cnt(c1), .progress(p[1]));
  seq_match_counter #(.SYM_W(2), .SEQ_LEN(3), .PATTERN(6'b11_10_01), .CNT_W(2)) u2 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .num(num),
    .hit(h[2]), .ans(a[2]), .hit_cnt(c2), .progress(p[2]));
  seq_match_counter #(.SYM_W(2), .SEQ_LEN(3), .PATTERN(6'b01_10_01), .CNT_W(8)) u3 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .num(num),
    .hit(h[3]), .ans(a[3]), .hit_cnt(c3), .progress(p[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // longest k<=maxk such that the last k stream symbols equal pattern symbols 0..k-1
  function automatic int longest(input int i, input int maxk);
    int n;
    bit good;
    n = mq[i].size();
    for (int k = maxk; k >= 1; k--) begin
      if (k <= n) begin
        good = 1'b1;
        for (int j = 0; j < k; j++)
          if (mq[i][n-k+j] != pat[i][j]) good = 1'b0;
        if (good) return k;
      end
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mq[i].delete();
      mp[i] = 0; mans[i] = 0; mhit[i] = 0; mcnt[i] = 0;
    end
  endtask

  task automatic model_step(input bit c, input bit v, input int s);
    int l;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        mq[i].delete();
        mp[i] = 0; mans[i] = 0; mhit[i] = 0; mcnt[i] = 0;
      end else if (v) begin
        mq[i].push_back(s);
        if (mq[i].size() > 3) void'(mq[i].pop_front());
        l = longest(i, 3);
        if (l == 3) begin
          mhit[i] = 1;
          mans[i] = 1;
          if (mcnt[i] < cmax[i]) mcnt[i]++;
          if (OVL) mp[i] = longest(i, 2);
          else begin
            mp[i] = 0;
            mq[i].delete();
          end
        end else begin
          mhit[i] = 0;
          mp[i] = l;
        end
      end else begin
        mhit[i] = 0;
      end
    end
  endtask

  task automatic check_all();
    logic [31:0] oc [4];
    oc[0] = {24'b0, c0};
    oc[1] = {24'b0, c1};
    oc[2] = {30'b0, c2};
    oc[3] = {24'b0, c3};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("u%0d_hit", i),  {31'b0, h[i]}, mhit[i]);
      chk($sformatf("u%0d_ans", i),  {31'b0, a[i]}, mans[i]);
      chk($sformatf("u%0d_cnt", i),  oc[i],         mcnt[i]);
      chk($sformatf("u%0d_prog", i), {30'b0, p[i]}, mp[i]);
    end
  endtask

  task automatic cyc(input bit c, input bit v, input int s);
    clear    = c;
    in_valid = v;
    num      = s[1:0];
    @(posedge clk);
    model_step(c, v, s);
    #1;
    check_all();
  endtask

  initial begin
    int s;
    bit c, v;
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; num = '0;
    model_reset();
    #12;
    check_all();
    reset = 1'b0;

    // basic 1,2,3
    cyc(0,1,1); cyc(0,1,2); cyc(0,1,3);
    chk("dir_hit_123", {31'b0, h[0]}, 1);
    chk("dir_cnt_123", {24'b0, c0}, 1);
    chk("dir_prog_123", {30'b0, p[0]}, 0);
    cyc(0,0,0);
    chk("dir_hit_pulse", {31'b0, h[0]}, 0);

    // fallback 1,2,1,2,3,0,0
    cyc(1,0,0);
    cyc(0,1,1); cyc(0,1,2); cyc(0,1,1); cyc(0,1,2);
    chk("dir_fallback_prog", {30'b0, p[0]}, 2);
    cyc(0,1,3); cyc(0,1,0); cyc(0,1,0);
    chk("dir_fallback_ans", {31'b0, a[0]}, 1);

    // in_valid gaps
    cyc(1,0,0);
    cyc(0,1,1); cyc(0,0,3); cyc(0,1,2); cyc(0,0,3); cyc(0,0,3);
    chk("dir_gap_prog", {30'b0, p[0]}, 2);
    cyc(0,1,3);

    // overlap pattern 1,1,1 with stream 1,1,1,1
    cyc(1,0,0);
    cyc(0,1,1); cyc(0,1,1); cyc(0,1,1); cyc(0,1,1);
    chk("dir_ovl_cnt", {24'b0, c1}, OVL ? 2 : 1);
    chk("dir_ovl_prog", {30'b0, p[1]}, OVL ? 2 : 1);

    // saturation with CNT_W=2
    cyc(1,0,0);
    for (int r = 0; r < 5; r++) begin
      cyc(0,1,1); cyc(0,1,2); cyc(0,1,3);
    end
    chk("dir_sat_cnt", {30'b0, c2}, 3);
    chk("dir_nosat_cnt", {24'b0, c0}, 5);

    // clear wins over in_valid
    cyc(1,1,1);
    chk("dir_clr_cnt", {24'b0, c0}, 0);
    chk("dir_clr_prog", {30'b0, p[0]}, 0);

    // asynchronous reset mid-stream
    cyc(0,1,1); cyc(0,1,2); cyc(0,1,3); cyc(0,1,1); cyc(0,1,2);
    #2 reset = 1'b1;
    #1 model_reset();
    check_all();
    chk("dir_arst_cnt", {24'b0, c0}, 0);
    #2 reset = 1'b0;
    cyc(0,1,3);
    chk("dir_arst_nohit", {31'b0, h[0]}, 0);

    // randomized stream
    for (int n = 0; n < 600; n++) begin
      c = ($urandom_range(0, 49) == 0);
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 3);
      cyc(c, v, s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_match_counter.md
# seq_match_counter

Parametrised streaming sequence detector: watches a stream of SYM_W-bit symbols for a programmable SEQ_LEN-symbol pattern. Mismatches fall back along the pattern's longest prefix/suffix (KMP-style), so the detector never misses a match. It reports each match as a one-cycle pulse, a sticky flag and a saturating match count. It is the generalised successor of the team's fixed 1-2-3 symbol detector, and sits between a symbol source and status/interrupt logic.

## Interface
- SYM_W, 2: symbol width in bits; SYM_W ≥ 1.
- SEQ_LEN, 3: pattern length in symbols; SEQ_LEN ≥ 2.
- PATTERN, 6'b11_10_01: concatenated pattern, width SYM_W*SEQ_LEN.
  - Symbol i = PATTERN[i*SYM_W +: SYM_W].
  - Symbol 0 is the first symbol expected; the default pattern is 1, 2, 3.
- CNT_W, 8: match counter width.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- clear  in  1  synchronous clear of progress, ans, hit and hit_cnt.
- in_valid  in  1  num is sampled on this edge when high.
- num  in  SYM_W  input symbol.
- hit  out  1  registered one-cycle pulse per completed match.
- ans  out  1  sticky match flag.
- hit_cnt  out  CNT_W  number of matches, saturating.
- progress  out  $clog2(SEQ_LEN+1)  current matched-prefix length, 0..SEQ_LEN-1.

## Operation
- State:
  - progress register P, 0..SEQ_LEN-1.
  - History of the last SEQ_LEN-1 accepted symbols.
  - ans, hit and hit_cnt registers.
- Accepted symbol: num on an edge where in_valid=1 and clear=0.
- Candidate length L: the largest k ≤ SEQ_LEN such that the last k accepted symbols, including the new one, equal pattern symbols 0..k-1. L is 0 if no such k exists.
- L < SEQ_LEN: P ← L, hit ← 0.
- L = SEQ_LEN (match):
  - hit ← 1.
  - ans ← 1.
  - hit_cnt ← hit_cnt+1, held at 2^CNT_W−1 once reached (no wrap).
  - P ← post-match value, see Configuration.
- No accepted symbol (in_valid=0, clear=0): P, history, ans and hit_cnt hold; hit ← 0.
- clear=1:
  - P, ans and hit_cnt go to 0 and hit goes to 0; history is invalidated.
  - num is discarded even if in_valid=1.
- ans stays high until clear or reset. Later matches keep it high.
- Symbols that match no prefix, e.g. 0 in the default pattern, drive P to 0.

## Timing
- Reset values: hit=0, ans=0, hit_cnt=0, progress=0; history is empty.
- reset asserted mid-stream clears everything asynchronously. The first symbol after release starts a fresh search.
- Latency: hit and ans rise in the cycle after the edge that samples the final pattern symbol, i.e. registered, one clock.
- hit_cnt updates on the same edge as hit.
- Back-to-back matches may produce hit high on consecutive cycles.
- Priority: reset > clear > in_valid.
- No combinational path from inputs to outputs.

## Configuration
- SEQ_OVERLAP_EN defined: overlapping matches count.
  - After a match, P ← length of the longest proper border of PATTERN that is a suffix of the stream.
  - Example: pattern 1,1,1 with stream 1,1,1,1 gives 2 hits.
- SEQ_OVERLAP_EN undefined: non-overlapping.
  - After a match, P ← 0 and history is invalidated; the matched symbols cannot start a new match.
  - Same example gives 1 hit, then P=1.
- For a border-free pattern such as the default 1,2,3, both modes are cycle-identical.

## Test plan
- Defaults, stream 1,2,3 with in_valid=1 every cycle:
  - hit pulses once, 1 cycle after the 3rd edge.
  - ans=1, hit_cnt=1, progress=0.
- Fallback, stream 1,2,1,2,3 then 0,0: exactly one hit after the 5th symbol; progress sequence 1,2,1,2,0,0,0; ans stays 1.
- in_valid gaps, 1,(gap),2,(gap,gap),3: one hit; progress holds during gaps; hit=0 in gap cycles.
- PATTERN=6'b01_01_01, stream 1,1,1,1:
  - With SEQ_OVERLAP_EN: hit_cnt=2.
  - Without: hit_cnt=1, progress=1.
- CNT_W=2, pattern 1,2,3 repeated 5 times:
  - hit_cnt sequence 1,2,3,3,3 (saturates); hit pulses 5 times.
  - clear together with in_valid=1 → all zero next cycle, symbol ignored.
- reset asserted asynchronously between clock edges with progress=2 and ans=1 → all outputs 0 before the next edge. Stream 3 after release produces no hit.
